// File: rtl/oven_cook_controller.sv
// Oven cook-cycle controller: keypad BCD MM:SS entry, 1 Hz countdown with door
// interlock and pause/cancel, heater enable and a timed end-of-cook beep.
module oven_cook_controller #(
    parameter int unsigned BEEP_SECS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_open,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       heater_on,
    output logic       done_beep,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] BEEP_INIT = 4'(BEEP_SECS);

    state_t     state_q, state_d;
    logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic       heater_q, heater_d;
    logic       beep_q, beep_d;

    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
    logic       dec_zero;
    logic       key_ok;
    logic       start_ok;

    // One-second BCD decrement with borrow chain; 00:00 never reaches here.
    always_comb begin
        dec_mt = mt_q;
        dec_mo = mo_q;
        dec_st = st_q;
        dec_so = so_q - 4'd1;
        if (so_q == 4'd0) begin
            dec_so = 4'd9;
            if (st_q == 4'd0) begin
                dec_st = 4'd5;
                if (mo_q == 4'd0) begin
                    dec_mo = 4'd9;
                    dec_mt = mt_q - 4'd1;
                end else begin
                    dec_mo = mo_q - 4'd1;
                end
            end else begin
                dec_st = st_q - 4'd1;
            end
        end
        dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);
    end

    assign key_ok   = key_valid && (key_digit <= 4'd9);
    assign start_ok = !door_open && ({mt_q, mo_q, st_q, so_q} != 16'h0000) && (st_q <= 4'd5);

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        bcnt_d  = bcnt_q;
        beep_d  = beep_q;

        unique case (state_q)
            S_IDLE: begin
                if (!stop_clear && key_ok) begin
                    {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, key_digit};
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (stop_clear) begin
                    {mt_d, mo_d, st_d, so_d} = 16'h0000;
                    state_d = S_IDLE;
                end else if (start) begin
                    // A start pulse always swallows a coincident key, accepted or not.
                    if (start_ok) begin
                        state_d = S_COOK;
                    end
                end else if (key_ok) begin
                    {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, key_digit};
                end
            end
            S_COOK: begin
                if (stop_clear || door_open) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    {mt_d, mo_d, st_d, so_d} = {dec_mt, dec_mo, dec_st, dec_so};
                    if (dec_zero) begin
                        state_d = S_DONE;
                        beep_d  = 1'b1;
                        bcnt_d  = BEEP_INIT;
                    end
                end
            end
            S_PAUSE: begin
                if (stop_clear) begin
                    {mt_d, mo_d, st_d, so_d} = 16'h0000;
                    state_d = S_IDLE;
                end else if (start && !door_open) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (stop_clear) begin
                    beep_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (tick) begin
                    bcnt_d = bcnt_q - 4'd1;
                    if (bcnt_q == 4'd1) begin
                        beep_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                {mt_d, mo_d, st_d, so_d} = 16'h0000;
                beep_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        heater_d = (state_d == S_COOK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mt_q     <= 4'd0;
            mo_q     <= 4'd0;
            st_q     <= 4'd0;
            so_q     <= 4'd0;
            bcnt_q   <= 4'd0;
            heater_q <= 1'b0;
            beep_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mt_q     <= mt_d;
            mo_q     <= mo_d;
            st_q     <= st_d;
            so_q     <= so_d;
            bcnt_q   <= bcnt_d;
            heater_q <= heater_d;
            beep_q   <= beep_d;
        end
    end

    assign min_tens  = mt_q;
    assign min_ones  = mo_q;
    assign sec_tens  = st_q;
    assign sec_ones  = so_q;
    assign heater_on = heater_q;
    assign done_beep = beep_q;
    assign state     = state_q;

endmodule

// File: tb/tb_oven_cook_controller.sv
// Self-checking bench for oven_cook_controller: vector table, scripted cook
// scenarios, then random traffic against a seconds-based reference model.
module tb_oven_cook_controller;

    localparam int TB_BEEP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop_clear = 1'b0;
    logic       door_open = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       heater_on, done_beep;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    oven_cook_controller #(.BEEP_SECS(TB_BEEP)) dut (
        .clk(clk), .reset(reset), .tick(tick), .key_valid(key_valid),
        .key_digit(key_digit), .start(start), .stop_clear(stop_clear),
        .door_open(door_open), .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .heater_on(heater_on),
        .done_beep(done_beep), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: entry held as four digits, running time as plain seconds.
    int m_st;
    int m_d[4];
    int m_secs;
    int m_bcnt;
    int m_beep;

    function automatic int m_disp();
        int mins, s;
        if (m_st == 2 || m_st == 3 || m_st == 4) begin
            mins = m_secs / 60;
            s    = m_secs % 60;
            return ((mins / 10) << 12) | ((mins % 10) << 8) | ((s / 10) << 4) | (s % 10);
        end
        return (m_d[0] << 12) | (m_d[1] << 8) | (m_d[2] << 4) | m_d[3];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        m_secs = 0;
    endtask

    task automatic m_shift(input int k);
        m_d[0] = m_d[1]; m_d[1] = m_d[2]; m_d[2] = m_d[3]; m_d[3] = k;
    endtask

    task automatic m_step(input bit r, input bit t, input bit kv, input int kd,
                          input bit s, input bit sc, input bit d);
        bit kok;
        kok = kv && (kd <= 9);
        if (r) begin
            m_st = 0; m_clear(); m_beep = 0; m_bcnt = 0;
        end else begin
            case (m_st)
                0: if (!sc && kok) begin m_shift(kd); m_st = 1; end
                1: begin
                    if (sc) begin m_clear(); m_st = 0; end
                    else if (s) begin
                        if (!d && m_disp() != 0 && m_d[2] <= 5) begin
                            m_secs = (m_d[0] * 10 + m_d[1]) * 60 + m_d[2] * 10 + m_d[3];
                            m_st = 2;
                        end
                    end else if (kok) m_shift(kd);
                end
                2: begin
                    if (sc || d) m_st = 3;
                    else if (t) begin
                        m_secs--;
                        if (m_secs == 0) begin m_st = 4; m_beep = 1; m_bcnt = TB_BEEP; end
                    end
                end
                3: begin
                    if (sc) begin m_clear(); m_st = 0; end
                    else if (s && !d) m_st = 2;
                end
                4: begin
                    if (sc) begin m_clear(); m_st = 0; m_beep = 0; end
                    else if (t) begin
                        m_bcnt--;
                        if (m_bcnt == 0) begin m_clear(); m_st = 0; m_beep = 0; end
                    end
                end
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int es, input int et, input int eh, input int eb);
        chk({tag, ".state"}, int'(state), es);
        chk({tag, ".time"}, int'({min_tens, min_ones, sec_tens, sec_ones}), et);
        chk({tag, ".heater"}, int'(heater_on), eh);
        chk({tag, ".beep"}, int'(done_beep), eb);
    endtask

    task automatic apply(input bit r, input bit t, input bit kv, input logic [3:0] kd,
                         input bit s, input bit sc, input bit d);
        reset = r; tick = t; key_valid = kv; key_digit = kd;
        start = s; stop_clear = sc; door_open = d;
        @(posedge clk);
        #1;
        m_step(r, t, kv, int'(kd), s, sc, d);
    endtask

    task automatic idle_cyc();       apply(0, 0, 0, 4'd0, 0, 0, 0); endtask
    task automatic key(input int k); apply(0, 0, 1, 4'(k), 0, 0, 0); endtask
    task automatic tk();             apply(0, 1, 0, 4'd0, 0, 0, 0); endtask
    task automatic go();             apply(0, 0, 0, 4'd0, 1, 0, 0); endtask
    task automatic stp();            apply(0, 0, 0, 4'd0, 0, 1, 0); endtask
    task automatic do_reset();
        apply(1, 0, 0, 4'd0, 0, 0, 0);
        idle_cyc();
    endtask

    typedef struct {
        bit rst, tk, kv;
        logic [3:0] kd;
        bit st, sc, dr;
        int es, et, eh, eb;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(bit r, bit t, bit kv, int kd, bit s, bit sc, bit d,
                                int es, int et, int eh, int eb);
        vec_t v;
        v.rst = r; v.tk = t; v.kv = kv; v.kd = 4'(kd); v.st = s; v.sc = sc; v.dr = d;
        v.es = es; v.et = et; v.eh = eh; v.eb = eb;
        return v;
    endfunction

    initial begin
        vt[0]  = mk(1,0,0,0, 0,0,0, 0,'h0000,0,0);
        vt[1]  = mk(0,0,0,0, 0,0,0, 0,'h0000,0,0);
        vt[2]  = mk(0,0,0,0, 1,0,0, 0,'h0000,0,0);
        vt[3]  = mk(0,0,1,12,0,0,0, 0,'h0000,0,0);
        vt[4]  = mk(0,0,1,7, 0,0,0, 1,'h0007,0,0);
        vt[5]  = mk(0,0,0,0, 0,1,0, 0,'h0000,0,0);
        vt[6]  = mk(0,0,1,9, 0,0,0, 1,'h0009,0,0);
        vt[7]  = mk(0,0,1,9, 0,0,0, 1,'h0099,0,0);
        vt[8]  = mk(0,0,1,9, 0,0,0, 1,'h0999,0,0);
        vt[9]  = mk(0,0,1,9, 0,0,0, 1,'h9999,0,0);
        vt[10] = mk(0,0,1,5, 0,0,0, 1,'h9995,0,0);
        vt[11] = mk(0,0,0,0, 1,0,0, 1,'h9995,0,0);
        vt[12] = mk(0,0,0,0, 0,1,0, 0,'h0000,0,0);
        vt[13] = mk(0,0,1,0, 0,0,0, 1,'h0000,0,0);
        vt[14] = mk(0,0,0,0, 1,0,0, 1,'h0000,0,0);
        vt[15] = mk(0,0,1,5, 1,0,0, 1,'h0000,0,0);
        vt[16] = mk(0,0,1,5, 0,0,0, 1,'h0005,0,0);
        vt[17] = mk(0,0,0,0, 1,0,1, 1,'h0005,0,0);
        vt[18] = mk(0,1,0,0, 1,0,0, 2,'h0005,1,0);
        vt[19] = mk(0,0,0,0, 0,1,0, 3,'h0005,0,0);
        vt[20] = mk(0,0,0,0, 0,1,0, 0,'h0000,0,0);

        for (int i = 0; i < 21; i++) begin
            apply(vt[i].rst, vt[i].tk, vt[i].kv, vt[i].kd, vt[i].st, vt[i].sc, vt[i].dr);
            chk_all($sformatf("vec%0d", i), vt[i].es, vt[i].et, vt[i].eh, vt[i].eb);
        end

        // 01:30 full cook, borrow chain and beep window
        do_reset();
        key(1); key(3); key(0);
        chk_all("cook130.entry", 1, 'h0130, 0, 0);
        go();
        chk_all("cook130.start", 2, 'h0130, 1, 0);
        tk();
        chk_all("cook130.t1", 2, 'h0129, 1, 0);
        for (int i = 2; i <= 30; i++) tk();
        chk_all("cook130.t30", 2, 'h0100, 1, 0);
        tk();
        chk_all("cook130.t31", 2, 'h0059, 1, 0);
        for (int i = 32; i <= 89; i++) tk();
        chk_all("cook130.t89", 2, 'h0001, 1, 0);
        tk();
        chk_all("cook130.done", 4, 'h0000, 0, 1);
        idle_cyc();
        chk_all("cook130.hold", 4, 'h0000, 0, 1);
        tk(); tk();
        chk_all("cook130.b2", 4, 'h0000, 0, 1);
        tk();
        chk_all("cook130.b3", 0, 'h0000, 0, 0);

        // Door interlock and resume
        key(5); go(); tk(); tk();
        chk_all("door.run", 2, 'h0003, 1, 0);
        apply(0, 1, 0, 4'd0, 0, 0, 1);
        chk_all("door.open", 3, 'h0003, 0, 0);
        apply(0, 0, 0, 4'd0, 1, 0, 1);
        chk_all("door.startopen", 3, 'h0003, 0, 0);
        go();
        chk_all("door.resume", 2, 'h0003, 1, 0);
        tk(); tk(); tk();
        chk_all("door.done", 4, 'h0000, 0, 1);
        stp();
        chk_all("door.cancelbeep", 0, 'h0000, 0, 0);

        // 10:00 pause then cancel
        key(1); key(0); key(0); key(0); go(); tk();
        chk_all("pause.t1", 2, 'h0959, 1, 0);
        stp();
        chk_all("pause.p", 3, 'h0959, 0, 0);
        tk();
        chk_all("pause.frozen", 3, 'h0959, 0, 0);
        stp();
        chk_all("pause.clear", 0, 'h0000, 0, 0);

        // Asynchronous reset mid-cook
        key(1); key(0); key(0); go(); tk();
        chk_all("rst.run", 2, 'h0059, 1, 0);
        reset = 1'b1;
        #2;
        chk("rst.async_heater", int'(heater_on), 0);
        chk("rst.async_state", int'(state), 0);
        m_step(1, 0, 0, 0, 0, 0, 0);
        idle_cyc();
        chk_all("rst.after", 0, 'h0000, 0, 0);

        // Random traffic against the model
        do_reset();
        begin
            bit dr;
            dr = 0;
            for (int n = 0; n < 4000; n++) begin
                bit r, t, kv, s, sc;
                int kd;
                if ($urandom_range(0, 99) < 4) dr = ~dr;
                r  = ($urandom_range(0, 999) < 4);
                t  = ($urandom_range(0, 99) < 40);
                kv = ($urandom_range(0, 99) < 20);
                kd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
                s  = ($urandom_range(0, 99) < 10);
                sc = ($urandom_range(0, 99) < 3);
                apply(r, t, kv, 4'(kd), s, sc, dr);
                chk_all($sformatf("rnd%0d", n), m_st, m_disp(), (m_st == 2) ? 1 : 0, m_beep);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
